// File: rtl/brent_wide_add_sched_if.sv
// ---------------------------------------------------------------------------
// brent_wide_add_sched_if
// Handshake bundle between the requesters and consumer (master side) and the
// shared-adder scheduler (slave side).
//   req0_*/req1_* : operation request channels (valid/ready, W-bit a/b, cin)
//   rsp_*         : result channel (valid/ready, W+1-bit sum, owner id)
//   busy          : scheduler is working on or holding an operation
// ---------------------------------------------------------------------------
interface brent_wide_add_sched_if #(
   parameter int W = 32
);
   logic         req0_valid;
   logic         req0_ready;
   logic [W-1:0] req0_a;
   logic [W-1:0] req0_b;
   logic         req0_cin;

   logic         req1_valid;
   logic         req1_ready;
   logic [W-1:0] req1_a;
   logic [W-1:0] req1_b;
   logic         req1_cin;

   logic         rsp_valid;
   logic         rsp_ready;
   logic [W:0]   rsp_sum;
   logic         rsp_id;
   logic         busy;

   modport master (
      output req0_valid, req0_a, req0_b, req0_cin,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_cin,
      input  req1_ready,
      input  rsp_valid, rsp_sum, rsp_id, busy,
      output rsp_ready
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_cin,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_cin,
      output req1_ready,
      output rsp_valid, rsp_sum, rsp_id, busy,
      input  rsp_ready
   );
endinterface

// File: rtl/brent_wide_add_sched.sv
// ---------------------------------------------------------------------------
// Brent
// N-bit Brent-Kung prefix adder (N a power of two).
//   A, B : operands
//   Cin  : carry-in
//   Sum  : {carry-out, N-bit sum}
//
// brent_wide_add_sched
// Round-robin scheduler that shares one Brent adder between two requesters
// and performs a W-bit add as W/N chunk additions, LSB chunk first, chaining
// the carry through a register.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of brent_wide_add_sched_if (requests, response, busy)
// ---------------------------------------------------------------------------
module Brent #(
   parameter int N = 8
) (
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Cin,
   output logic [N:0]   Sum
);
   localparam int LG = $clog2(N);

   logic [N-1:0] p_bit;
   logic [N-1:0] g_pre;
   logic [N-1:0] p_pre;
   logic [N:0]   carry;

   always_comb begin
      p_bit = A ^ B;
      g_pre = A & B;
      p_pre = p_bit;
      // Up-sweep: bit i (1-based) that is a multiple of 2^(l+1) absorbs the
      // group ending 2^l positions below it. Sources are never updated in
      // the same level, so in-place update is safe.
      for (int l = 0; l < LG; l++) begin
         for (int b = 0; b < N; b++) begin
            if (((b + 1) % (2 << l)) == 0) begin
               g_pre[b] = g_pre[b] | (p_pre[b] & g_pre[b - (1 << l)]);
               p_pre[b] = p_pre[b] & p_pre[b - (1 << l)];
            end
         end
      end
      // Down-sweep: fill the odd multiples of 2^l from the complete prefix
      // 2^l positions below.
      for (int l = LG - 2; l >= 0; l--) begin
         for (int b = 0; b < N; b++) begin
            if ((((b + 1) % (2 << l)) == (1 << l)) && ((b + 1) > (1 << l))) begin
               g_pre[b] = g_pre[b] | (p_pre[b] & g_pre[b - (1 << l)]);
               p_pre[b] = p_pre[b] & p_pre[b - (1 << l)];
            end
         end
      end
      // Fold the external carry-in into every prefix.
      carry[0] = Cin;
      for (int b = 0; b < N; b++) begin
         carry[b + 1] = g_pre[b] | (p_pre[b] & Cin);
      end
      Sum = {carry[N], p_bit ^ carry[N-1:0]};
   end
endmodule

module brent_wide_add_sched #(
   parameter int W = 32,
   parameter int N = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   brent_wide_add_sched_if.slave  bus
);
   localparam int K  = W / N;
   localparam int KW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  op_a_q, op_a_d;
   logic [W-1:0]  op_b_q, op_b_d;
   logic          carry_q, carry_d;
   logic [KW-1:0] k_q, k_d;
   logic          last_grant_q, last_grant_d;
   logic [W:0]    rsp_sum_q, rsp_sum_d;
   logic          rsp_id_q, rsp_id_d;

   logic          grant0, grant1;
   logic          accept0, accept1;
   logic [N-1:0]  add_a, add_b;
   logic          add_cin;
   logic [N:0]    add_sum;

   // Grant is "nobody" when no requester is valid, so both readies are low
   // in that case. On a tie the requester that did not win last goes.
   always_comb begin
      grant0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
      grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
   end

   assign bus.req0_ready = (state_q == S_IDLE) && !rst && grant0;
   assign bus.req1_ready = (state_q == S_IDLE) && !rst && grant1;
   assign accept0        = bus.req0_valid && bus.req0_ready;
   assign accept1        = bus.req1_valid && bus.req1_ready;

   // Adder sees the current chunk only while running; zero otherwise.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (state_q == S_RUN) begin
         add_a   = op_a_q[k_q*N +: N];
         add_b   = op_b_q[k_q*N +: N];
         add_cin = carry_q;
      end
   end

   Brent #(.N(N)) u_adder (
      .A   (add_a),
      .B   (add_b),
      .Cin (add_cin),
      .Sum (add_sum)
   );

   always_comb begin
      state_d      = state_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      carry_d      = carry_q;
      k_d          = k_q;
      last_grant_d = last_grant_q;
      rsp_sum_d    = rsp_sum_q;
      rsp_id_d     = rsp_id_q;
      case (state_q)
         S_IDLE: begin
            if (accept0 || accept1) begin
               op_a_d       = accept1 ? bus.req1_a   : bus.req0_a;
               op_b_d       = accept1 ? bus.req1_b   : bus.req0_b;
               carry_d      = accept1 ? bus.req1_cin : bus.req0_cin;
               rsp_id_d     = accept1;
               last_grant_d = accept1;
               k_d          = '0;
               state_d      = S_RUN;
            end
         end
         S_RUN: begin
            rsp_sum_d[k_q*N +: N] = add_sum[N-1:0];
            carry_d               = add_sum[N];
            if (k_q == KW'(K - 1)) begin
               // Final chunk: its carry-out is the top bit of the result.
               rsp_sum_d[W] = add_sum[N];
               state_d      = S_DONE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         S_DONE: begin
            if (bus.rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         op_a_q       <= '0;
         op_b_q       <= '0;
         carry_q      <= 1'b0;
         k_q          <= '0;
         last_grant_q <= 1'b1;
         rsp_sum_q    <= '0;
         rsp_id_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         carry_q      <= carry_d;
         k_q          <= k_d;
         last_grant_q <= last_grant_d;
         rsp_sum_q    <= rsp_sum_d;
         rsp_id_q     <= rsp_id_d;
      end
   end

   assign bus.rsp_valid = (state_q == S_DONE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.rsp_sum   = rsp_sum_q;
   assign bus.rsp_id    = rsp_id_q;
endmodule

// File: doc/brent_wide_add_sched.md
# brent_wide_add_sched

Shared-adder scheduler around one 8-bit `Brent` Brent-Kung adder (ports `A`, `B`, `Cin`, `Sum[8:0]`). It arbitrates between two requesters, round-robin. It then sequences a W-bit addition through the single adder one N-bit chunk per cycle, least-significant chunk first, chaining the carry. It returns a W+1-bit sum on a valid/ready response port. It sits between the requesting datapath blocks and the adder, which it instantiates exactly once.

## Interface

**Parameters**
- `W`, default 32: operand width. Must be a multiple of `N`.
- `N`, default 8: chunk width. Must equal the `Brent` adder width.
- `K` (local): `W/N` chunks per operation.

**Ports**
- `clk`  in  1  rising-edge clock. The block has one clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 operation accepted this cycle when high together with `req0_valid`.
- `req0_a`, `req0_b`  in  W  requester 0 operands.
- `req0_cin`  in  1  requester 0 carry-in.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cin`: same meanings as the requester 0 ports, for requester 1.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_sum`  out  W+1  `a + b + cin`, with the carry-out in bit W.
- `rsp_id`  out  1  index of the requester that owns the result.
- `busy`  out  1  high in RUN or DONE.

## Operation

**States**
- IDLE → RUN on accept.
- RUN → DONE after chunk `K-1`.
- DONE → IDLE on `rsp_valid && rsp_ready`.

**Grant (IDLE only)**
- Only one `reqX_valid` high: that requester is granted.
- Both high: grant the requester that is not `last_grant`.
- `last_grant` resets to 1, so requester 0 wins the first tie.
- `reqX_ready = (state==IDLE) && !rst && grant==X`. This is combinational from state and valids; it never depends on `rsp_ready`.
- Accept = `reqX_valid && reqX_ready`. On the accept edge:
  - latch a, b and cin into `op_a`, `op_b` and `carry`;
  - latch the requester index into `rsp_id`;
  - set `last_grant` = X;
  - clear chunk counter `k`.
- Outside IDLE, both readies are 0 and requester inputs are ignored.

**RUN (chunk k)**
- Adder driven with `A=op_a[k*N +: N]`, `B=op_b[k*N +: N]`, `Cin=carry`.
- On the edge:
  - `rsp_sum[k*N +: N] <= Sum[N-1:0]`;
  - `carry <= Sum[N]`;
  - `k <= k+1`.
- At `k==K-1`: `rsp_sum[W] <= Sum[N]` and the state goes to DONE.
- `k` never wraps past `K-1`.

**DONE**
- `rsp_valid=1`.
- `rsp_sum` and `rsp_id` are held stable until the handshake.
- Then IDLE, with `rsp_valid=0` on the next cycle.

**Outputs**
- `rsp_sum` retains its last value outside DONE; only `rsp_valid` qualifies it.
- Adder inputs are driven to 0 outside RUN.

**Arithmetic**
- Unsigned, modulo-free. `rsp_sum` is exactly `{1'b0,a} + {1'b0,b} + cin`, so no overflow is possible at W+1 bits.

**Reset**
- Synchronous. Applies in any state, including mid-RUN and DONE.
- Next-cycle values: state IDLE, `k=0`, `carry=0`, `last_grant=1`, `rsp_valid=0`, `rsp_sum=0`, `rsp_id=0`, `busy=0`, `req0_ready=req1_ready=0`.
- An operation in flight is dropped with no response.

## Timing

- Accept at edge E0 → RUN during cycles E0..E(K-1) → `rsp_valid` high after edge E(K). This is a K-cycle latency, 4 for the defaults.
- Best-case throughput is one operation per K+2 cycles: K RUN cycles, 1 DONE cycle with `rsp_ready=1`, and 1 IDLE cycle.
- `rsp_ready` low stalls in DONE indefinitely. No new request is accepted while stalled.
- If a requester drops valid before it is accepted, nothing happens; there is no latching of requests.
- The arbiter has no starvation. With both requesters continuously valid, grants alternate 0,1,0,1.

## Test plan

1. **Single request, carry-out.** Reset, then `req0`: `a=0xFFFFFFFF`, `b=0x00000001`, `cin=0`, with `rsp_ready=1`. Required: `rsp_sum=0x1_00000000`, `rsp_id=0`, `rsp_valid` first high exactly 4 cycles after the accept edge, and `busy` high for 5 cycles.
2. **Carry-in propagation.** `req1`: `a=0x7FFFFFFF`, `b=0x80000000`, `cin=1`. Required: `rsp_sum=0x1_00000000`, `rsp_id=1`. Then `a=0x12345678`, `b=0x11111111`, `cin=0` → `0x0_23456789`.
3. **Arbitration.** Both valid from reset, each holding 3 ops. Required: response `rsp_id` sequence 0,1,0,1,0,1, and `req0_ready` and `req1_ready` never high in the same cycle.
4. **Backpressure.** Hold `rsp_ready=0` for 6 cycles in DONE. Required: `rsp_valid`, `rsp_sum` and `rsp_id` stable throughout; both readies 0; completion 1 cycle after `rsp_ready` rises.
5. **Reset mid-RUN.** Assert `rst` for 1 cycle after 2 chunks. Required: the next cycle shows all outputs at reset values and no `rsp_valid` for the aborted op. The following op `0x0000FFFF + 0x00000001` → `0x0_00010000` completes correctly.
6. **Random compare.** 10k random a, b and cin per requester, with random `reqX_valid` and `rsp_ready`. Required: every `rsp_sum` equals `a+b+cin` for the matching `rsp_id`, in accept order.
